// File: rtl/parking_request_intake.sv
// parking_request_intake
//   Request-side responder for the parking lot operator port. Single-cycle
//   park/retrieve pulses with a BCD license plate are validated, queued in a
//   small circular FIFO, and handed to the elevator controller one at a time.
//   Each request is held until req_ready, followed by one all-zero gap cycle.
//
// Build option:
//   PLATE_DEDUP_EN  when defined, a valid request whose {mode,plate} matches
//                   any queued entry is dropped and dup_drop pulses. When
//                   undefined, duplicates are queued and dup_drop is tied 0.
//
// Ports:
//   clock                   in   system clock, posedge
//   reset                   in   synchronous, active-low
//   license_plate           in   operator plate (4 BCD digits when PLATE_W=16)
//   in_mode / out_mode      in   1-cycle park / retrieve request
//   req_ready               in   controller accepts the presented request
//   in_mode_internal        out  presented request is park
//   out_mode_internal       out  presented request is retrieve
//   license_plate_internal  out  presented plate, 0 when nothing presented
//   pending_count           out  queued entries including the presented one
//   overflow                out  pulse: request dropped, queue full
//   invalid_req             out  pulse: malformed request rejected
//   dup_drop                out  pulse: duplicate request dropped
module parking_request_intake #(
  parameter int DEPTH   = 4,
  parameter int PLATE_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [PLATE_W-1:0] license_plate,
  input  logic               in_mode,
  input  logic               out_mode,
  input  logic               req_ready,
  output logic               in_mode_internal,
  output logic               out_mode_internal,
  output logic [PLATE_W-1:0] license_plate_internal,
  output logic [4:0]         pending_count,
  output logic               overflow,
  output logic               invalid_req,
  output logic               dup_drop
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [4:0]         r_count;
  logic               r_overflow;
  logic               r_invalid;
  logic               r_dup;

  // Queue storage: mode bit is 1 for park, 0 for retrieve.
  logic               r_mem_mode  [DEPTH];
  logic [PLATE_W-1:0] r_mem_plate [DEPTH];

  logic w_any_req;
  logic w_malformed;
  logic w_valid;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_dup;
  logic w_full_drop;

  // A plate is well-formed when non-zero and every nibble is a BCD digit.
  function automatic logic plate_ok(input logic [PLATE_W-1:0] p);
    logic ok;
    ok = (p != '0);
    for (int k = 0; k < PLATE_W / 4; k++) begin
      if (p[4*k +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  assign w_any_req   = in_mode | out_mode;
  assign w_malformed = w_any_req & ((in_mode & out_mode) | ~plate_ok(license_plate));
  assign w_valid     = (in_mode ^ out_mode) & plate_ok(license_plate);
  assign w_full      = (r_count == 5'(DEPTH));
  assign w_pop       = (r_state == PRESENT) & req_ready;
  // A pop on a full queue frees the slot the push lands in.
  assign w_full_drop = w_valid & w_full & ~w_pop;

`ifdef PLATE_DEDUP_EN
  // Compare against every occupied slot, the presented head included.
  always_comb begin
    w_dup = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((5'(i) < r_count) &&
          (r_mem_mode[r_rptr + PTR_W'(i)] == in_mode) &&
          (r_mem_plate[r_rptr + PTR_W'(i)] == license_plate))
        w_dup = 1'b1;
    end
  end
`else
  assign w_dup = 1'b0;
`endif

  assign w_push = w_valid & ~w_full_drop & ~w_dup;

  // Control state: pointers, occupancy, FSM and status pulses
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_invalid  <= 1'b0;
      r_dup      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_overflow <= w_full_drop;
      r_invalid  <= w_malformed;
      r_dup      <= w_valid & ~w_full_drop & w_dup;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue payload; pointers alone define occupancy, so no reset is needed here.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem_mode[r_wptr]  <= in_mode;
      r_mem_plate[r_wptr] <= license_plate;
    end
  end

  // Next state and presented outputs. IDLE and GAP both move to PRESENT only
  // once the queue already holds an entry, giving the one-edge presentation
  // latency after a push and a single zero cycle between requests.
  always_comb begin
    w_state_nxt            = r_state;
    in_mode_internal       = 1'b0;
    out_mode_internal      = 1'b0;
    license_plate_internal = '0;
    case (r_state)
      IDLE: begin
        if (r_count != 5'd0) w_state_nxt = PRESENT;
      end
      PRESENT: begin
        in_mode_internal       = r_mem_mode[r_rptr];
        out_mode_internal      = ~r_mem_mode[r_rptr];
        license_plate_internal = r_mem_plate[r_rptr];
        if (req_ready) w_state_nxt = GAP;
      end
      GAP: begin
        w_state_nxt = (r_count != 5'd0) ? PRESENT : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign pending_count = r_count;
  assign overflow      = r_overflow;
  assign invalid_req   = r_invalid;
  assign dup_drop      = r_dup;

endmodule

// File: tb/tb_parking_request_intake.sv
module tb_parking_request_intake;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] license_plate;
  logic        in_mode;
  logic        out_mode;
  logic        req_ready;
  logic        in_mode_internal;
  logic        out_mode_internal;
  logic [15:0] license_plate_internal;
  logic [4:0]  pending_count;
  logic        overflow;
  logic        invalid_req;
  logic        dup_drop;

  parking_request_intake #(.DEPTH(DEPTH), .PLATE_W(16)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .license_plate          (license_plate),
    .in_mode                (in_mode),
    .out_mode               (out_mode),
    .req_ready              (req_ready),
    .in_mode_internal       (in_mode_internal),
    .out_mode_internal      (out_mode_internal),
    .license_plate_internal (license_plate_internal),
    .pending_count          (pending_count),
    .overflow               (overflow),
    .invalid_req            (invalid_req),
    .dup_drop               (dup_drop)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit          park;
    logic [15:0] plate;
  } ent_t;

  // Reference model: a plain FIFO of requests plus "is the head on display".
  ent_t q[$];
  bit   m_pres = 1'b0;
  bit   e_ovf  = 1'b0;
  bit   e_inv  = 1'b0;
  bit   e_dup  = 1'b0;

  logic [15:0] pool [8] = '{16'h9423, 16'h8754, 16'h1234, 16'h0001,
                            16'h9999, 16'h9A23, 16'h0000, 16'hF000};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit bcd_plate(input logic [15:0] p);
    int v;
    v = int'(p);
    if (v == 0) return 1'b0;
    for (int k = 0; k < 4; k++) begin
      if ((v / (16 ** k)) % 16 > 9) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_step(input bit i_in, input bit i_out, input logic [15:0] pl,
                            input bit rdy, input bit rst_n);
    int sz;
    bit pop, valid, full, dup;
    if (!rst_n) begin
      q.delete();
      m_pres = 1'b0;
      e_ovf  = 1'b0;
      e_inv  = 1'b0;
      e_dup  = 1'b0;
    end else begin
      sz    = q.size();
      pop   = m_pres && rdy;
      valid = (i_in != i_out) && bcd_plate(pl);
      e_inv = (i_in || i_out) && ((i_in && i_out) || !bcd_plate(pl));
      full  = (sz == DEPTH);
      dup   = 1'b0;
`ifdef PLATE_DEDUP_EN
      foreach (q[j]) if (q[j].park == i_in && q[j].plate == pl) dup = 1'b1;
`endif
      e_ovf = valid && full && !pop;
      e_dup = valid && !e_ovf && dup;
      if (pop) void'(q.pop_front());
      if (valid && !e_ovf && !e_dup) q.push_back('{park: i_in, plate: pl});
      m_pres = m_pres ? !pop : (sz > 0);
    end
  endtask

  task automatic step(input bit i_in, input bit i_out, input logic [15:0] pl,
                      input bit rdy, input bit rst_n);
    bit          x_in, x_out;
    logic [15:0] x_pl;
    reset         = rst_n;
    in_mode       = i_in;
    out_mode      = i_out;
    license_plate = pl;
    req_ready     = rdy;
    @(posedge clock);
    #1;
    model_step(i_in, i_out, pl, rdy, rst_n);
    x_in  = 1'b0;
    x_out = 1'b0;
    x_pl  = 16'h0;
    if (m_pres && q.size() > 0) begin
      x_in  = q[0].park;
      x_out = !q[0].park;
      x_pl  = q[0].plate;
    end
    check_val("in_mode_internal",  32'(in_mode_internal),       32'(x_in));
    check_val("out_mode_internal", 32'(out_mode_internal),      32'(x_out));
    check_val("plate_internal",    32'(license_plate_internal), 32'(x_pl));
    check_val("pending_count",     32'(pending_count),          32'(q.size()));
    check_val("overflow",          32'(overflow),               32'(e_ovf));
    check_val("invalid_req",       32'(invalid_req),            32'(e_inv));
    check_val("dup_drop",          32'(dup_drop),               32'(e_dup));
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, rdy, 1'b1);
  endtask

  initial begin
    // Reset state
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h9423, 1'b0, 1'b0);

    // Single park request, controller ready
    step(1'b1, 1'b0, 16'h9423, 1'b1, 1'b1);
    idle(4, 1'b1);

    // Two requests, controller holds off for a while
    step(1'b1, 1'b0, 16'h9423, 1'b0, 1'b1);
    step(1'b1, 1'b0, 16'h8754, 1'b0, 1'b1);
    idle(5, 1'b0);
    idle(6, 1'b1);

    // Fill past full, then push with a concurrent pop when full
    step(1'b1, 1'b0, 16'h1111, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'h2222, 1'b0, 1'b1);
    step(1'b1, 1'b0, 16'h3333, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'h4444, 1'b0, 1'b1);
    step(1'b1, 1'b0, 16'h5555, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'h6666, 1'b1, 1'b1);

    // Malformed requests
    step(1'b1, 1'b0, 16'h9A23, 1'b0, 1'b1);
    step(1'b1, 1'b1, 16'h9423, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'h0000, 1'b0, 1'b1);

    // Reset while presenting with entries queued; same-cycle push ignored
    step(1'b1, 1'b0, 16'h7777, 1'b0, 1'b0);
    idle(2, 1'b0);

    // Back-to-back identical retrieve requests
    step(1'b0, 1'b1, 16'h8754, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'h8754, 1'b0, 1'b1);
    idle(3, 1'b0);
    idle(8, 1'b1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int  r;
      bit  si, so, rdy, rn;
      r   = int'($urandom_range(0, 9));
      si  = (r == 0) || (r == 2);
      so  = (r == 1) || (r == 2) || (r == 3);
      rdy = ($urandom_range(0, 3) == 0);
      rn  = ($urandom_range(0, 199) != 0);
      step(si, so, pool[$urandom_range(0, 7)], rdy, rn);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
